march_bist_ctrl: RTL

March C- built-in self-test controller that acts as the initiator for the team's single-port synchronous `memory` block. It drives `read`/`write`/`address`/`data_in` and checks the memory's registered `data_out`. It sits beside the memory under test and reports `done` and `fail` plus the first-failure location to the chip-level test logic. One memory op is issued per cycle, and read checks are pipelined one cycle behind the read.

---
 rtl/march_bist_ctrl_if.sv | 31 +++
 rtl/march_bist_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/march_bist_ctrl_if.sv
// Memory-side bus and test status of the March C- BIST controller.
// master = controller, slave = memory under test plus chip-level test logic.
interface march_bist_ctrl_if #(
  parameter int a_width = 4,
  parameter int width   = 4
);
  logic               start;
  logic               mem_read;
  logic               mem_write;
  logic [a_width-1:0] mem_address;
  logic [width-1:0]   mem_data_in;
  logic [width-1:0]   mem_data_out;
  logic               busy;
  logic               done;
  logic               fail;
  logic [a_width-1:0] fail_address;
  logic [2:0]         fail_element;
  logic [width-1:0]   fail_data;

  modport master (
    input  start, mem_data_out,
    output mem_read, mem_write, mem_address, mem_data_in,
    output busy, done, fail, fail_address, fail_element, fail_data
  );

  modport slave (
    output start, mem_data_out,
    input  mem_read, mem_write, mem_address, mem_data_in,
    input  busy, done, fail, fail_address, fail_element, fail_data
  );
endinterface

// File: rtl/march_bist_ctrl.sv
// March C- BIST initiator: one registered memory op per cycle over 10N cycles, read checks one cycle behind.
// Run takes 10N+1 busy cycles; start is ignored while busy, first miscompare is captured and the run completes.
module march_bist_ctrl #(
  parameter int a_width = 4,
  parameter int width   = 4
) (
  input  logic               clk,
  input  logic               rst,
  march_bist_ctrl_if.master  bus
);

  localparam logic [a_width-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t             r_state;
  logic [2:0]         r_elem;
  logic               r_phase;
  logic [a_width-1:0] r_addr;

  logic               r_read;
  logic               r_write;
  logic [a_width-1:0] r_mem_addr;
  logic [width-1:0]   r_mem_din;

  logic               r_busy;
  logic               r_done;
  logic               r_fail;
  logic [a_width-1:0] r_fail_addr;
  logic [2:0]         r_fail_elem;
  logic [width-1:0]   r_fail_data;

  logic               r_pend;
  logic [width-1:0]   r_exp;
  logic [a_width-1:0] r_chk_addr;
  logic [2:0]         r_chk_elem;

  logic               w_at_term;
  logic               w_last;
  logic [2:0]         w_nxt_elem;
  logic               w_nxt_phase;
  logic [a_width-1:0] w_nxt_addr;
  logic               w_nxt_wr;
  logic               w_miscmp;

  function automatic logic f_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic f_two_op(input logic [2:0] e);
    return (e != 3'd0) && (e != 3'd5);
  endfunction

  function automatic logic [width-1:0] f_wr_pat(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? {width{1'b1}} : {width{1'b0}};
  endfunction

  function automatic logic [width-1:0] f_rd_pat(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? {width{1'b1}} : {width{1'b0}};
  endfunction

  // Next op derived from the op currently on the bus; w_last marks the final M5 read.
  always_comb begin
    w_at_term   = f_down(r_elem) ? (r_addr == '0) : (r_addr == ADDR_LAST);
    w_nxt_elem  = r_elem;
    w_nxt_phase = 1'b0;
    w_nxt_addr  = r_addr;
    w_last      = 1'b0;
    if (f_two_op(r_elem) && !r_phase) begin
      w_nxt_phase = 1'b1;
    end else if (w_at_term) begin
      if (r_elem == 3'd5) begin
        w_last = 1'b1;
      end else begin
        w_nxt_elem = 3'(r_elem + 3'd1);
        w_nxt_addr = f_down(w_nxt_elem) ? ADDR_LAST : '0;
      end
    end else begin
      w_nxt_addr = f_down(r_elem) ? (r_addr - 1'b1) : (r_addr + 1'b1);
    end
    w_nxt_wr = (w_nxt_elem == 3'd0) || (f_two_op(w_nxt_elem) && w_nxt_phase);
    w_miscmp = r_pend && (bus.mem_data_out != r_exp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_elem      <= 3'd0;
      r_phase     <= 1'b0;
      r_addr      <= '0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= 3'd0;
      r_fail_data <= '0;
      r_pend      <= 1'b0;
      r_exp       <= '0;
      r_chk_addr  <= '0;
      r_chk_elem  <= 3'd0;
    end else begin
      // The read on the bus this cycle is checked against data_out next cycle.
      r_pend     <= r_read;
      r_exp      <= f_rd_pat(r_elem);
      r_chk_addr <= r_mem_addr;
      r_chk_elem <= r_elem;

      if (w_miscmp && !r_fail) begin
        r_fail      <= 1'b1;
        r_fail_addr <= r_chk_addr;
        r_fail_elem <= r_chk_elem;
        r_fail_data <= bus.mem_data_out;
      end

      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state     <= RUN;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= 3'd0;
            r_fail_data <= '0;
            r_elem      <= 3'd0;
            r_phase     <= 1'b0;
            r_addr      <= '0;
            r_read      <= 1'b0;
            r_write     <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
          end
        end
        RUN: begin
          if (w_last) begin
            r_state    <= FLUSH;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
          end else begin
            r_elem     <= w_nxt_elem;
            r_phase    <= w_nxt_phase;
            r_addr     <= w_nxt_addr;
            r_read     <= !w_nxt_wr;
            r_write    <= w_nxt_wr;
            r_mem_addr <= w_nxt_addr;
            r_mem_din  <= w_nxt_wr ? f_wr_pat(w_nxt_elem) : '0;
          end
        end
        FLUSH: begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_read     = r_read;
  assign bus.mem_write    = r_write;
  assign bus.mem_address  = r_mem_addr;
  assign bus.mem_data_in  = r_mem_din;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.fail         = r_fail;
  assign bus.fail_address = r_fail_addr;
  assign bus.fail_element = r_fail_elem;
  assign bus.fail_data    = r_fail_data;

endmodule
